sdram_cmd_sequencer: RTL and testbench
======================================

// Module: sdram_cmd_sequencer
// PURPOSE
//  Registered FSM that generates the 4-bit SDRAM command code, 22-bit address and MRS word
//  consumed by the command truth-table decoder downstream.
//  Runs power-up init (wait, PALL, 2xREF, MRS), then periodic auto-refresh.
//  Serves single-word read/write requests as ACT -> READA/WRITA with auto-precharge, honouring timing.
// PARAMETERS
//  T_INIT    20000   power-up wait before PALL, in clk cycles
//  T_RP      2       cycles from PRE/PALL/auto-precharge to next ACT/REF
//  T_RFC     7       cycles from REF to next command
//  T_MRD     2       cycles from MRS to next command
//  T_RCD     2       cycles from ACT to READA/WRITA
//  CAS_LAT   2       cycles from READA to read data on bus
//  T_WR      2       write recovery before auto-precharge starts
//  T_REFI    780     refresh interval in cycles
//  MRS_VALUE 12'h020 mode word (CL2, burst length 1, sequential)
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   synchronous reset, active-low
//  req_valid  in   1   access request present
//  req_ready  out  1   sequencer accepts request this cycle
//  req_write  in   1   1 = write, 0 = read
//  req_addr   in   22  {bank[21:20], row[19:8], col[7:0]}
//  command    out  4   command code to decoder
//  addr_out   out  22  address to decoder (captured req_addr during ACT/READA/WRITA, else 0)
//  mrs        out  12  constant MRS_VALUE
//  init_done  out  1   high from first IDLE entry until reset
//  wr_strobe  out  1   high in the cycle WRITA is on command; datapath drives DQ
//  rd_strobe  out  1   high CAS_LAT cycles after READA; datapath samples DQ
// BEHAVIOUR
//  Codes: DESL 0000, NOP 0001, MRS 0010, ACT 0011, READA 0101, WRITA 0111, PALL 1001, REF 1011.
//  Other codes are never issued.
//  All outputs are registered.
//  Reset: command=NOP, addr_out=0, req_ready=0, init_done=0, wr/rd_strobe=0.
//  Reset also clears the FSM to INIT_WAIT, the refresh counter, ref_pending and all wait counters.
//  A command is asserted for exactly one cycle; every other cycle outputs NOP.
//  Wait rule: after issuing a command with gap T, the next command appears T cycles later
//  (T-1 NOP cycles in between).
//  Init: INIT_WAIT holds NOP for T_INIT cycles, then:
//    PALL -(T_RP)-> REF -(T_RFC)-> REF -(T_RFC)-> MRS -(T_MRD)-> IDLE.
//    init_done rises on IDLE entry.
//  Refresh timer: counts only after init_done; sets ref_pending on reaching T_REFI-1, reloads to 0.
//    If ref_pending is already set, it stays set (one pending max, no queueing).
//  IDLE priority: ref_pending beats request.
//    Refresh: REF issued next cycle, ref_pending cleared; T_RFC later the FSM returns to IDLE.
//  req_ready = 1 only in IDLE with init_done=1 and ref_pending=0.
//    Transfer when req_valid&&req_ready; req_write/req_addr are captured and held internally.
//  Access, request accepted in cycle N:
//    ACT at N+1 with addr_out=captured address.
//    READA/WRITA at N+1+T_RCD.
//    Read: rd_strobe at READA cycle + CAS_LAT; FSM returns to IDLE CAS_LAT+T_RP cycles after READA.
//    Write: wr_strobe with WRITA; FSM returns to IDLE T_WR+T_RP cycles after WRITA.
//  ref_pending set mid-access does not abort the access; refresh is served at the next IDLE.
//  req_valid while not ready: ignored, no capture.
//    Requester must hold req_valid/req_addr/req_write stable until the handshake.
//  rst_n low mid-operation: next cycle is the reset state; init restarts fully (T_INIT wait repeated).
//  Counters: wait counter sized for max(T_INIT,T_REFI); no wrap in normal use.
// TESTING
//  (bench overrides: T_INIT=10, T_REFI=50, others at default)
//  1 Reset release -> 10 NOPs, PALL, NOP, REF, 6 NOP, REF, 6 NOP, MRS(mrs=12'h020), NOP.
//    Then init_done=1, req_ready=1.
//  2 Read req_addr=22'h2ABC12 -> ACT addr_out=22'h2ABC12; READA 2 cycles later;
//    rd_strobe 2 cycles after READA; req_ready back 4 cycles after READA.
//  3 Write req_addr=22'h012345 -> ACT, WRITA 2 cycles later with wr_strobe=1;
//    req_ready back 4 cycles after WRITA.
//  4 Idle after init -> REF every 50 cycles.
//    Refresh due in same cycle as req_valid -> REF issued first, request accepted after T_RFC.
//  5 Back-to-back req_valid held high -> second ACT no earlier than CAS_LAT+T_RP+1 cycles after first READA.
//    No ACT within T_RCD of READA.
//  6 rst_n low during RCD wait -> next cycle command=NOP, init_done=0; full init sequence repeats.

Source files
------------

// File: rtl/sdram_cmd_sequencer.sv
// sdram_cmd_sequencer
//   Registered FSM producing SDRAM command codes, addresses and the mode word for
//   a downstream command truth-table decoder. It runs the power-up init sequence
//   (wait, PALL, 2x REF, MRS) and then periodic auto-refresh. It also serves
//   single-word read and write accesses as ACT followed by READA or WRITA, which
//   use auto-precharge.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (transfer on valid && ready)
//   req_write, req_addr   access type and {bank[21:20], row[19:8], col[7:0]}
//   command               4-bit command code; NOP on every cycle without a command
//   addr_out              captured address on ACT/READA/WRITA cycles, else 0
//   mrs                   constant mode-register word
//   init_done             high from the first IDLE entry until reset
//   wr_strobe             high in the WRITA cycle (datapath drives DQ)
//   rd_strobe             high CAS_LAT cycles after READA (datapath samples DQ)
module sdram_cmd_sequencer #(
  parameter int          T_INIT    = 20000,
  parameter int          T_RP      = 2,
  parameter int          T_RFC     = 7,
  parameter int          T_MRD     = 2,
  parameter int          T_RCD     = 2,
  parameter int          CAS_LAT   = 2,
  parameter int          T_WR      = 2,
  parameter int          T_REFI    = 780,
  parameter logic [11:0] MRS_VALUE = 12'h020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [21:0] req_addr,
  output logic [3:0]  command,
  output logic [21:0] addr_out,
  output logic [11:0] mrs,
  output logic        init_done,
  output logic        wr_strobe,
  output logic        rd_strobe
);

  // One counter width covers the longest wait (init or refresh interval).
  localparam int MAXT = (T_INIT > T_REFI) ? T_INIT : T_REFI;
  localparam int CW   = $clog2(MAXT + 1);

  // Command codes. DESL (0000) exists in the decoder but is never issued here.
  localparam logic [3:0] CMD_NOP   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0010;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READA = 4'b0101;
  localparam logic [3:0] CMD_WRITA = 4'b0111;
  localparam logic [3:0] CMD_PALL  = 4'b1001;
  localparam logic [3:0] CMD_REF   = 4'b1011;

  typedef struct packed {
    logic        write;
    logic [21:0] addr;
  } req_t;

  // Each state names the action taken once wait_cnt has drained to zero.
  typedef enum logic [2:0] {
    INIT_WAIT,
    INIT_REF1,
    INIT_REF2,
    INIT_MRS,
    GO_IDLE,
    IDLE,
    ACCESS
  } state_t;

  state_t          state;
  req_t            cap;
  logic [CW-1:0]   init_cnt;
  logic [CW-1:0]   wait_cnt;
  logic [CW-1:0]   ref_cnt;
  logic            ref_pending;
  logic [CAS_LAT:0] rd_pipe;
  logic            ref_set;
  logic            ref_hold;

  // ref_set fires on the same edge that raises ref_pending. req_ready uses it so
  // that the ready flag drops in the same cycle the refresh becomes pending.
  always_comb begin
    ref_set  = init_done && (ref_cnt == CW'(T_REFI - 1));
    ref_hold = ref_pending || ref_set;
  end

  // rd_pipe[0] is loaded on the READA edge; its last stage lands CAS_LAT cycles later.
  assign rd_strobe = rd_pipe[CAS_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= INIT_WAIT;
      command     <= CMD_NOP;
      addr_out    <= '0;
      req_ready   <= 1'b0;
      init_done   <= 1'b0;
      wr_strobe   <= 1'b0;
      rd_pipe     <= '0;
      init_cnt    <= '0;
      wait_cnt    <= '0;
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      cap         <= '0;
      mrs         <= MRS_VALUE;
    end else begin
      mrs       <= MRS_VALUE;
      command   <= CMD_NOP;
      addr_out  <= '0;
      wr_strobe <= 1'b0;
      rd_pipe   <= {rd_pipe[CAS_LAT-1:0], 1'b0};

      // Refresh interval timer. At most one refresh can be pending at a time.
      if (init_done) begin
        if (ref_set) ref_cnt <= '0;
        else         ref_cnt <= ref_cnt + CW'(1);
      end
      if (ref_set) ref_pending <= 1'b1;

      // A command loads wait_cnt with gap-1. The next action runs on the first
      // edge after the counter has drained to zero.
      if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - CW'(1);
      end else begin
        unique case (state)
          INIT_WAIT: begin
            if (init_cnt == CW'(T_INIT)) begin
              command  <= CMD_PALL;
              wait_cnt <= CW'(T_RP - 1);
              state    <= INIT_REF1;
            end else begin
              init_cnt <= init_cnt + CW'(1);
            end
          end
          INIT_REF1: begin
            command  <= CMD_REF;
            wait_cnt <= CW'(T_RFC - 1);
            state    <= INIT_REF2;
          end
          INIT_REF2: begin
            command  <= CMD_REF;
            wait_cnt <= CW'(T_RFC - 1);
            state    <= INIT_MRS;
          end
          INIT_MRS: begin
            command  <= CMD_MRS;
            wait_cnt <= CW'(T_MRD - 1);
            state    <= GO_IDLE;
          end
          GO_IDLE: begin
            init_done <= 1'b1;
            req_ready <= !ref_hold;
            state     <= IDLE;
          end
          IDLE: begin
            if (req_valid && req_ready) begin
              command   <= CMD_ACT;
              addr_out  <= req_addr;
              cap       <= '{write: req_write, addr: req_addr};
              req_ready <= 1'b0;
              wait_cnt  <= CW'(T_RCD - 1);
              state     <= ACCESS;
            end else if (ref_pending) begin
              command     <= CMD_REF;
              ref_pending <= ref_set;
              req_ready   <= 1'b0;
              wait_cnt    <= CW'(T_RFC - 1);
              state       <= GO_IDLE;
            end else begin
              req_ready <= !ref_set;
            end
          end
          ACCESS: begin
            addr_out <= cap.addr;
            if (cap.write) begin
              command   <= CMD_WRITA;
              wr_strobe <= 1'b1;
              // Auto-precharge begins after write recovery, then tRP.
              wait_cnt  <= CW'(T_WR + T_RP - 1);
            end else begin
              command    <= CMD_READA;
              rd_pipe[0] <= 1'b1;
              // Auto-precharge overlaps the CAS latency; the bank is free after CL + tRP.
              wait_cnt   <= CW'(CAS_LAT + T_RP - 1);
            end
            state <= GO_IDLE;
          end
          default: state <= INIT_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Directed bench for sdram_cmd_sequencer with T_INIT=10 and T_REFI=50.
// cyc counts clock edges since reset release, so edge k is the cycle observed as cyc==k.
// Inputs are driven and outputs sampled on the falling edge.
module tb_sdram_cmd_sequencer;

  localparam logic [3:0] NOP = 4'b0001, MRS = 4'b0010, ACT = 4'b0011, RDA = 4'b0101,
                         WRA = 4'b0111, PALL = 4'b1001, REF = 4'b1011;

  logic        clk, rst_n, req_valid, req_ready, req_write;
  logic [21:0] req_addr, addr_out;
  logic [3:0]  command;
  logic [11:0] mrs;
  logic        init_done, wr_strobe, rd_strobe;
  int          cyc;
  int          errors = 0;
  int          checks = 0;

  sdram_cmd_sequencer #(.T_INIT(10), .T_REFI(50)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .command(command),
    .addr_out(addr_out), .mrs(mrs), .init_done(init_done),
    .wr_strobe(wr_strobe), .rd_strobe(rd_strobe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: sim time exceeded, required finish");
    $fatal(1);
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (command !== NOP) begin errors++; $display("FAIL rst_cmd: got=%h exp=%h", command, NOP); end
    checks++; if (addr_out !== 22'h0) begin errors++; $display("FAIL rst_addr: got=%h exp=0", addr_out); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got=%b exp=0", req_ready); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got=%b exp=0", init_done); end
    checks++; if (wr_strobe !== 1'b0 || rd_strobe !== 1'b0) begin
      errors++; $display("FAIL rst_strobes: got=%b%b exp=00", wr_strobe, rd_strobe);
    end
  endtask

  // Release reset at a falling edge and check the init command sequence edge by edge.
  task automatic test_init();
    logic [3:0] e;
    rst_n = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      e = (k == 11) ? PALL : (k == 13 || k == 20) ? REF : (k == 27) ? MRS : NOP;
      checks++; if (command !== e) begin errors++; $display("FAIL init_cmd: k=%0d got=%h exp=%h", k, command, e); end
      if (k == 27) begin
        checks++; if (mrs !== 12'h020) begin errors++; $display("FAIL init_mrs: got=%h exp=020", mrs); end
      end
      if (k == 28) begin
        checks++; if (init_done !== 1'b0 || req_ready !== 1'b0) begin
          errors++; $display("FAIL init_early: done=%b ready=%b exp=0 0", init_done, req_ready);
        end
      end
    end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done: got=%b exp=1", init_done); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL init_ready: got=%b exp=1", req_ready); end
  endtask

  // Starts at cyc 29: handshake on edge 30, ACT 30, READA 32, rd_strobe 34, ready 36.
  task automatic test_read();
    logic [3:0] e;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 22'h2ABC12;
    for (int k = 30; k <= 36; k++) begin
      @(negedge clk);
      e = (k == 30) ? ACT : (k == 32) ? RDA : NOP;
      checks++; if (command !== e) begin errors++; $display("FAIL rd_cmd: cyc=%0d got=%h exp=%h", cyc, command, e); end
      checks++; if (addr_out !== ((k == 30 || k == 32) ? 22'h2ABC12 : 22'h0)) begin
        errors++; $display("FAIL rd_addr: cyc=%0d got=%h", cyc, addr_out);
      end
      checks++; if (rd_strobe !== (k == 34)) begin errors++; $display("FAIL rd_strobe: cyc=%0d got=%b", cyc, rd_strobe); end
      checks++; if (req_ready !== (k == 36)) begin errors++; $display("FAIL rd_ready: cyc=%0d got=%b", cyc, req_ready); end
      if (k == 30) req_valid = 1'b0;
    end
  endtask

  // Starts at cyc 36: ACT 37, WRITA+wr_strobe 39, ready 43.
  task automatic test_write();
    logic [3:0] e;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 22'h012345;
    for (int k = 37; k <= 43; k++) begin
      @(negedge clk);
      e = (k == 37) ? ACT : (k == 39) ? WRA : NOP;
      checks++; if (command !== e) begin errors++; $display("FAIL wr_cmd: cyc=%0d got=%h exp=%h", cyc, command, e); end
      checks++; if (addr_out !== ((k == 37 || k == 39) ? 22'h012345 : 22'h0)) begin
        errors++; $display("FAIL wr_addr: cyc=%0d got=%h", cyc, addr_out);
      end
      checks++; if (wr_strobe !== (k == 39) || rd_strobe !== 1'b0) begin
        errors++; $display("FAIL wr_strobe: cyc=%0d got=%b%b", cyc, wr_strobe, rd_strobe);
      end
      checks++; if (req_ready !== (k == 43)) begin errors++; $display("FAIL wr_ready: cyc=%0d got=%b", cyc, req_ready); end
      if (k == 37) req_valid = 1'b0;
    end
  endtask

  // Refresh becomes pending on edges 79 and 129 and is issued one edge later.
  // A request raised while the refresh is pending waits for REF plus tRFC.
  task automatic test_refresh();
    logic [3:0] e;
    logic       r;
    for (int k = 44; k <= 129; k++) begin
      @(negedge clk);
      e = (k == 80) ? REF : NOP;
      r = !((k >= 79 && k <= 86) || k == 129);
      checks++; if (command !== e) begin errors++; $display("FAIL ref_cmd: cyc=%0d got=%h exp=%h", cyc, command, e); end
      checks++; if (req_ready !== r) begin errors++; $display("FAIL ref_ready: cyc=%0d got=%b exp=%b", cyc, req_ready, r); end
    end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 22'h3FFFFF;
    for (int k = 130; k <= 144; k++) begin
      @(negedge clk);
      e = (k == 130) ? REF : (k == 138) ? ACT : (k == 140) ? RDA : NOP;
      r = (k == 137 || k == 144);
      checks++; if (command !== e) begin errors++; $display("FAIL refq_cmd: cyc=%0d got=%h exp=%h", cyc, command, e); end
      checks++; if (req_ready !== r) begin errors++; $display("FAIL refq_ready: cyc=%0d got=%b exp=%b", cyc, req_ready, r); end
      checks++; if (addr_out !== ((k == 138 || k == 140) ? 22'h3FFFFF : 22'h0)) begin
        errors++; $display("FAIL refq_addr: cyc=%0d got=%h", cyc, addr_out);
      end
      checks++; if (rd_strobe !== (k == 142)) begin errors++; $display("FAIL refq_rd: cyc=%0d got=%b", cyc, rd_strobe); end
      if (k == 138) req_valid = 1'b0;
    end
  endtask

  // req_valid is held high: READA comes at 147, and the second ACT waits until 152.
  task automatic test_back_to_back();
    logic [3:0] e;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 22'h155555;
    for (int k = 145; k <= 158; k++) begin
      @(negedge clk);
      e = (k == 145 || k == 152) ? ACT : (k == 147 || k == 154) ? RDA : NOP;
      checks++; if (command !== e) begin errors++; $display("FAIL b2b_cmd: cyc=%0d got=%h exp=%h", cyc, command, e); end
      checks++; if (rd_strobe !== (k == 149 || k == 156)) begin
        errors++; $display("FAIL b2b_rd: cyc=%0d got=%b", cyc, rd_strobe);
      end
      checks++; if (req_ready !== (k == 151 || k == 158)) begin
        errors++; $display("FAIL b2b_ready: cyc=%0d got=%b", cyc, req_ready);
      end
      if (k == 152) req_valid = 1'b0;
    end
  endtask

  // A write is accepted at edge 159. Reset is asserted during the RCD wait.
  // WRITA must not appear, and init must restart from the beginning.
  task automatic test_reset_mid();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 22'h0ABCDE;
    @(negedge clk);
    checks++; if (command !== ACT) begin errors++; $display("FAIL rm_act: got=%h exp=%h", command, ACT); end
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (command !== NOP) begin errors++; $display("FAIL rm_cmd: got=%h exp=%h", command, NOP); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rm_init_done: got=%b exp=0", init_done); end
    checks++; if (req_ready !== 1'b0 || addr_out !== 22'h0 || wr_strobe !== 1'b0) begin
      errors++; $display("FAIL rm_state: ready=%b addr=%h wr=%b exp=0 0 0", req_ready, addr_out, wr_strobe);
    end
    test_init();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 22'h0;
    test_reset();
    test_init();
    test_read();
    test_write();
    test_refresh();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
